// File: rtl/mtap_ctrl_pkg.sv
// Shared TAP controller types: 1149.1 state encodings, IR capture pattern and next-state rule.
package mtap_ctrl_pkg;

    typedef enum logic [3:0] {
        TAP_EX2_DR = 4'h0,
        TAP_EX1_DR = 4'h1,
        TAP_SH_DR  = 4'h2,
        TAP_PAU_DR = 4'h3,
        TAP_SEL_IR = 4'h4,
        TAP_UPD_DR = 4'h5,
        TAP_CAP_DR = 4'h6,
        TAP_SEL_DR = 4'h7,
        TAP_EX2_IR = 4'h8,
        TAP_EX1_IR = 4'h9,
        TAP_SH_IR  = 4'hA,
        TAP_PAU_IR = 4'hB,
        TAP_RTI    = 4'hC,
        TAP_UPD_IR = 4'hD,
        TAP_CAP_IR = 4'hE,
        TAP_TLR    = 4'hF
    } tap_state_t;

    localparam logic [1:0] IR_CAPTURE_PAT = 2'b01;

    // 1149.1 transition graph; any state not named under a tms value holds.
    function automatic tap_state_t tap_next(input tap_state_t s, input logic tms);
        tap_state_t n;
        n = s;
        unique case (s)
            TAP_TLR:    n = tms ? TAP_TLR    : TAP_RTI;
            TAP_RTI:    n = tms ? TAP_SEL_DR : TAP_RTI;
            TAP_SEL_DR: n = tms ? TAP_SEL_IR : TAP_CAP_DR;
            TAP_SEL_IR: n = tms ? TAP_TLR    : TAP_CAP_IR;
            TAP_CAP_DR: n = tms ? TAP_EX1_DR : TAP_SH_DR;
            TAP_SH_DR:  n = tms ? TAP_EX1_DR : TAP_SH_DR;
            TAP_EX1_DR: n = tms ? TAP_UPD_DR : TAP_PAU_DR;
            TAP_PAU_DR: n = tms ? TAP_EX2_DR : TAP_PAU_DR;
            TAP_EX2_DR: n = tms ? TAP_UPD_DR : TAP_SH_DR;
            TAP_UPD_DR: n = tms ? TAP_SEL_DR : TAP_RTI;
            TAP_CAP_IR: n = tms ? TAP_EX1_IR : TAP_SH_IR;
            TAP_SH_IR:  n = tms ? TAP_EX1_IR : TAP_SH_IR;
            TAP_EX1_IR: n = tms ? TAP_UPD_IR : TAP_PAU_IR;
            TAP_PAU_IR: n = tms ? TAP_EX2_IR : TAP_PAU_IR;
            TAP_EX2_IR: n = tms ? TAP_UPD_IR : TAP_SH_IR;
            TAP_UPD_IR: n = tms ? TAP_SEL_DR : TAP_RTI;
            default:    n = TAP_TLR;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mtap_tap_fsm.sv
// 16-state TAP FSM; state qualifiers are flopped from the next state so they align with the state register.
module mtap_tap_fsm
    import mtap_ctrl_pkg::*;
(
    input  logic       tck_i,
    input  logic       trst_b_i,
    input  logic       tms_i,
    output tap_state_t state_o,
    output logic       tlrs_o,
    output logic       capture_dr_o,
    output logic       shift_dr_o,
    output logic       update_dr_o,
    output logic       shift_ir_o
);

    tap_state_t state_q, state_d;
    logic       tlrs_q, capture_dr_q, shift_dr_q, update_dr_q, shift_ir_q;

    always_comb begin
        state_d = tap_next(state_q, tms_i);
    end

    always_ff @(posedge tck_i or negedge trst_b_i) begin
        if (!trst_b_i) begin
            state_q      <= TAP_TLR;
            tlrs_q       <= 1'b1;
            capture_dr_q <= 1'b0;
            shift_dr_q   <= 1'b0;
            update_dr_q  <= 1'b0;
            shift_ir_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            tlrs_q       <= (state_d == TAP_TLR);
            capture_dr_q <= (state_d == TAP_CAP_DR);
            shift_dr_q   <= (state_d == TAP_SH_DR);
            update_dr_q  <= (state_d == TAP_UPD_DR);
            shift_ir_q   <= (state_d == TAP_SH_IR);
        end
    end

    assign state_o      = state_q;
    assign tlrs_o       = tlrs_q;
    assign capture_dr_o = capture_dr_q;
    assign shift_dr_o   = shift_dr_q;
    assign update_dr_o  = update_dr_q;
    assign shift_ir_o   = shift_ir_q;

endmodule

// File: rtl/mtap_tap_ctrl.sv
// mTAP sequencer: TAP FSM plus IR shift/hold registers and the one-hot DR select decoder.
module mtap_tap_ctrl
    import mtap_ctrl_pkg::*;
#(
    parameter int unsigned CTRL_IR_WIDTH = 8,
    parameter int unsigned CTRL_NUM_REGS = 4,
    parameter logic [CTRL_NUM_REGS*CTRL_IR_WIDTH-1:0] CTRL_OPCODES = {8'h11, 8'h10, 8'h0C, 8'hFF},
    parameter logic [CTRL_IR_WIDTH-1:0] CTRL_IR_RESET_VAL = 8'h0C
) (
    input  logic                     atappris_tck,
    input  logic                     powergoodrst_trst_b,
    input  logic                     ftap_tms,
    input  logic                     ftap_tdi,
    output logic [3:0]               mtap_fsm_state,
    output logic                     mtap_fsm_tlrs,
    output logic                     mtap_fsm_capture_dr,
    output logic                     mtap_fsm_shift_dr,
    output logic                     mtap_fsm_update_dr,
    output logic                     mtap_fsm_shift_ir,
    output logic                     mtap_irreg_serial_out,
    output logic [CTRL_IR_WIDTH-1:0] mtap_irreg_ir,
    output logic [CTRL_NUM_REGS-1:0] mtap_irdecoder_drselect
);

    tap_state_t                 state;
    logic [CTRL_IR_WIDTH-1:0]   ir_sh_q, ir_sh_d;
    logic [CTRL_IR_WIDTH-1:0]   ir_hold_q, ir_hold_d;
    logic [CTRL_NUM_REGS-1:0]   drsel;
    logic                       hit;

    mtap_tap_fsm u_fsm (
        .tck_i        (atappris_tck),
        .trst_b_i     (powergoodrst_trst_b),
        .tms_i        (ftap_tms),
        .state_o      (state),
        .tlrs_o       (mtap_fsm_tlrs),
        .capture_dr_o (mtap_fsm_capture_dr),
        .shift_dr_o   (mtap_fsm_shift_dr),
        .update_dr_o  (mtap_fsm_update_dr),
        .shift_ir_o   (mtap_fsm_shift_ir)
    );

    // Hold only ever loads a complete shreg in UPD_IR, so a reset mid-shift can never leak partial bits.
    always_comb begin
        ir_sh_d   = ir_sh_q;
        ir_hold_d = ir_hold_q;
        if (state == TAP_CAP_IR) begin
            ir_sh_d = CTRL_IR_WIDTH'(IR_CAPTURE_PAT);
        end else if (state == TAP_SH_IR) begin
            ir_sh_d = {ftap_tdi, ir_sh_q[CTRL_IR_WIDTH-1:1]};
        end
        if (state == TAP_UPD_IR) begin
            ir_hold_d = ir_sh_q;
        end else if (state == TAP_TLR) begin
            ir_hold_d = CTRL_IR_RESET_VAL;
        end
    end

    always_ff @(posedge atappris_tck or negedge powergoodrst_trst_b) begin
        if (!powergoodrst_trst_b) begin
            ir_sh_q   <= '0;
            ir_hold_q <= CTRL_IR_RESET_VAL;
        end else begin
            ir_sh_q   <= ir_sh_d;
            ir_hold_q <= ir_hold_d;
        end
    end

    // Lowest matching slot wins; no match falls back to BYPASS in slot 0.
    always_comb begin
        drsel = '0;
        hit   = 1'b0;
        for (int unsigned i = 0; i < CTRL_NUM_REGS; i++) begin
            if (!hit && (ir_hold_q == CTRL_OPCODES[i*CTRL_IR_WIDTH +: CTRL_IR_WIDTH])) begin
                drsel[i] = 1'b1;
                hit      = 1'b1;
            end
        end
        if (!hit) begin
            drsel = CTRL_NUM_REGS'(1);
        end
    end

    assign mtap_fsm_state          = state;
    assign mtap_irreg_serial_out   = ir_sh_q[0];
    assign mtap_irreg_ir           = ir_hold_q;
    assign mtap_irdecoder_drselect = drsel;

endmodule

// File: tb/tb_mtap_tap_ctrl.sv
// Bench for mtap_tap_ctrl: vector table, directed IR/DR sequences and a random walk against a table-driven TAP model.
module tb_mtap_tap_ctrl;

    localparam logic [31:0] DEF_OPS = {8'h11, 8'h10, 8'h0C, 8'hFF};
    localparam logic [31:0] DUP_OPS = {8'h22, 8'h10, 8'h22, 8'hFF};

    logic clk = 1'b0;
    logic rst_n, tms_r, tdi_r;
    always #5 clk = ~clk;

    logic [3:0] st, d_st;
    logic       tlrs, capdr, shdr, upddr, shir, so;
    logic       d_tlrs, d_capdr, d_shdr, d_upddr, d_shir, d_so;
    logic [7:0] ir, d_ir;
    logic [3:0] sel, d_sel;

    mtap_tap_ctrl dut (
        .atappris_tck(clk), .powergoodrst_trst_b(rst_n), .ftap_tms(tms_r), .ftap_tdi(tdi_r),
        .mtap_fsm_state(st), .mtap_fsm_tlrs(tlrs), .mtap_fsm_capture_dr(capdr),
        .mtap_fsm_shift_dr(shdr), .mtap_fsm_update_dr(upddr), .mtap_fsm_shift_ir(shir),
        .mtap_irreg_serial_out(so), .mtap_irreg_ir(ir), .mtap_irdecoder_drselect(sel)
    );

    mtap_tap_ctrl #(.CTRL_OPCODES(DUP_OPS)) dut_dup (
        .atappris_tck(clk), .powergoodrst_trst_b(rst_n), .ftap_tms(tms_r), .ftap_tdi(tdi_r),
        .mtap_fsm_state(d_st), .mtap_fsm_tlrs(d_tlrs), .mtap_fsm_capture_dr(d_capdr),
        .mtap_fsm_shift_dr(d_shdr), .mtap_fsm_update_dr(d_upddr), .mtap_fsm_shift_ir(d_shir),
        .mtap_irreg_serial_out(d_so), .mtap_irreg_ir(d_ir), .mtap_irdecoder_drselect(d_sel)
    );

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model: transition graph as lookup tables, IR as plain shift arithmetic.
    int         nxt0[16], nxt1[16];
    int         m_state;
    logic [7:0] m_sh, m_ir;

    typedef struct {
        logic       tms;
        logic       tdi;
        logic [3:0] st;
        logic       so;
        logic [7:0] ir;
        logic [3:0] sel;
    } vec_t;
    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] ref_sel(input logic [31:0] tbl, input logic [7:0] v);
        for (int i = 0; i < 4; i++) begin
            if (tbl[i*8 +: 8] == v) return 4'(1 << i);
        end
        return 4'b0001;
    endfunction

    task automatic add_arc(input int from, input int tmsv, input int to);
        if (tmsv != 0) nxt1[from] = to;
        else nxt0[from] = to;
    endtask

    task automatic build_model();
        for (int s = 0; s < 16; s++) begin
            nxt0[s] = s;
            nxt1[s] = s;
        end
        add_arc(15, 0, 12); add_arc(12, 1, 7);
        add_arc(7, 0, 6);   add_arc(7, 1, 4);
        add_arc(4, 0, 14);  add_arc(4, 1, 15);
        add_arc(6, 0, 2);   add_arc(6, 1, 1);   add_arc(14, 0, 10); add_arc(14, 1, 9);
        add_arc(2, 1, 1);   add_arc(10, 1, 9);
        add_arc(1, 0, 3);   add_arc(1, 1, 5);   add_arc(9, 0, 11);  add_arc(9, 1, 13);
        add_arc(3, 1, 0);   add_arc(11, 1, 8);
        add_arc(0, 0, 2);   add_arc(0, 1, 5);   add_arc(8, 0, 10);  add_arc(8, 1, 13);
        add_arc(5, 0, 12);  add_arc(5, 1, 7);   add_arc(13, 0, 12); add_arc(13, 1, 7);
    endtask

    task automatic model_reset();
        m_state = 15;
        m_sh    = 8'h00;
        m_ir    = 8'h0C;
    endtask

    task automatic model_edge(input logic tmsv, input logic tdiv);
        if (m_state == 13) m_ir = m_sh;
        else if (m_state == 15) m_ir = 8'h0C;
        if (m_state == 14) m_sh = 8'h01;
        else if (m_state == 10) m_sh = (m_sh >> 1) | (tdiv ? 8'h80 : 8'h00);
        m_state = tmsv ? nxt1[m_state] : nxt0[m_state];
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".state"}, 32'(st), 32'(m_state));
        chk({tag, ".tlrs"}, 32'(tlrs), 32'(m_state == 15));
        chk({tag, ".capture_dr"}, 32'(capdr), 32'(m_state == 6));
        chk({tag, ".shift_dr"}, 32'(shdr), 32'(m_state == 2));
        chk({tag, ".update_dr"}, 32'(upddr), 32'(m_state == 5));
        chk({tag, ".shift_ir"}, 32'(shir), 32'(m_state == 10));
        chk({tag, ".serial_out"}, 32'(so), 32'(m_sh[0]));
        chk({tag, ".ir"}, 32'(ir), 32'(m_ir));
        chk({tag, ".drselect"}, 32'(sel), 32'(ref_sel(DEF_OPS, m_ir)));
        chk({tag, ".dup_core"}, {12'h0, d_st, d_tlrs, d_capdr, d_shdr, d_upddr, d_shir, d_so, d_ir},
            {12'h0, 4'(m_state), m_state == 15, m_state == 6, m_state == 2, m_state == 5,
             m_state == 10, m_sh[0], m_ir});
        chk({tag, ".dup_drselect"}, 32'(d_sel), 32'(ref_sel(DUP_OPS, m_ir)));
    endtask

    task automatic step(input logic tmsv, input logic tdiv, input string tag);
        tms_r = tmsv;
        tdi_r = tdiv;
        @(posedge clk);
        model_edge(tmsv, tdiv);
        #1;
        check_all(tag);
    endtask

    task automatic go_tlr(input string tag);
        repeat (5) step(1'b1, 1'($urandom_range(0, 1)), tag);
    endtask

    // From TLR: enter SH_IR, shift val LSB-first, optionally detour through PAU_IR after bit pause_at.
    task automatic load_ir(input logic [7:0] val, input int pause_at, input string tag);
        go_tlr(tag);
        step(1'b0, 1'b0, tag); step(1'b1, 1'b0, tag); step(1'b1, 1'b0, tag);
        step(1'b0, 1'b0, tag); step(1'b0, 1'b0, tag);
        for (int i = 0; i < 8; i++) begin
            if (i == pause_at) begin
                step(1'b1, val[i], tag);
                step(1'b0, 1'b0, tag);
                repeat (10) step(1'b0, 1'($urandom_range(0, 1)), tag);
                step(1'b1, 1'b0, tag);
                step(1'b0, 1'b0, tag);
            end else begin
                step(i == 7, val[i], tag);
            end
        end
        step(1'b1, 1'b0, tag);
        step(1'b0, 1'b0, tag);
        chk({tag, ".final_ir"}, 32'(ir), 32'(val));
    endtask

    function automatic vec_t mk(input logic t, input logic d, input logic [3:0] s,
                                input logic o, input logic [7:0] i, input logic [3:0] sl);
        vec_t v;
        v.tms = t; v.tdi = d; v.st = s; v.so = o; v.ir = i; v.sel = sl;
        return v;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        build_model();
        model_reset();
        rst_n = 1'b0;
        tms_r = 1'b1;
        tdi_r = 1'b0;
        repeat (2) @(negedge clk);
        check_all("reset");
        chk("reset.state_F", 32'(st), 32'hF);
        chk("reset.ir_0C", 32'(ir), 32'h0C);
        chk("reset.drselect_idcode", 32'(sel), 32'b0010);
        rst_n = 1'b1;

        // IR load of 8'hFF from TLR, checked row by row.
        vecs[0] = mk(0, 0, 4'hC, 0, 8'h0C, 4'b0010);
        vecs[1] = mk(1, 0, 4'h7, 0, 8'h0C, 4'b0010);
        vecs[2] = mk(1, 0, 4'h4, 0, 8'h0C, 4'b0010);
        vecs[3] = mk(0, 0, 4'hE, 0, 8'h0C, 4'b0010);
        vecs[4] = mk(0, 1, 4'hA, 1, 8'h0C, 4'b0010);
        for (int i = 5; i < 12; i++) vecs[i] = mk(0, 1, 4'hA, 0, 8'h0C, 4'b0010);
        vecs[12] = mk(1, 1, 4'h9, 1, 8'h0C, 4'b0010);
        vecs[13] = mk(1, 0, 4'hD, 1, 8'h0C, 4'b0010);
        vecs[14] = mk(0, 0, 4'hC, 1, 8'hFF, 4'b0001);
        for (int i = 0; i < 15; i++) begin
            step(vecs[i].tms, vecs[i].tdi, "vec");
            chk($sformatf("vec%0d.state", i), 32'(st), 32'(vecs[i].st));
            chk($sformatf("vec%0d.serial_out", i), 32'(so), 32'(vecs[i].so));
            chk($sformatf("vec%0d.ir", i), 32'(ir), 32'(vecs[i].ir));
            chk($sformatf("vec%0d.drselect", i), 32'(sel), 32'(vecs[i].sel));
        end

        load_ir(8'h10, -1, "slot2");
        chk("slot2.drselect", 32'(sel), 32'b0100);
        step(1'b1, 1'b0, "dr"); step(1'b0, 1'b0, "dr");
        chk("dr.capture_dr", 32'(capdr), 32'd1);
        chk("dr.no_shift_in_cap", 32'(shdr), 32'd0);
        repeat (4) begin
            step(1'b0, 1'($urandom_range(0, 1)), "dr");
            chk("dr.shift_dr", 32'(shdr), 32'd1);
        end
        step(1'b1, 1'b0, "dr");
        chk("dr.shift_dr_exit", 32'(shdr), 32'd0);
        step(1'b1, 1'b0, "dr");
        chk("dr.update_dr", 32'(upddr), 32'd1);
        step(1'b0, 1'b0, "dr");

        load_ir(8'h3C, 3, "pause");
        chk("pause.drselect", 32'(sel), 32'b0001);

        go_tlr("rst");
        step(1'b0, 1'b0, "rst"); step(1'b1, 1'b0, "rst"); step(1'b1, 1'b0, "rst");
        step(1'b0, 1'b0, "rst"); step(1'b0, 1'b0, "rst");
        repeat (3) step(1'b0, 1'b1, "rst");
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("rst_async");
        chk("rst_async.state_F", 32'(st), 32'hF);
        chk("rst_async.ir_0C", 32'(ir), 32'h0C);
        #1;
        rst_n = 1'b1;
        load_ir(8'hA5, -1, "rst_reload");

        load_ir(8'h22, -1, "dup");
        chk("dup.drselect_lowest", 32'(d_sel), 32'b0010);
        chk("dup.default_table_bypass", 32'(sel), 32'b0001);
        load_ir(8'h55, -1, "nomatch");
        chk("nomatch.dup_bypass", 32'(d_sel), 32'b0001);

        // Five tms=1 edges from every state.
        for (int s = 0; s < 16; s++) begin
            for (int k = 0; k < 400 && m_state != s; k++) begin
                step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "walk");
            end
            chk($sformatf("walk.reach_%0h", s), 32'(st), 32'(s));
            go_tlr("tlr5");
            chk($sformatf("tlr5.from_%0h", s), 32'(st), 32'hF);
            chk($sformatf("tlr5.tlrs_%0h", s), 32'(tlrs), 32'd1);
            step(1'b1, 1'b0, "tlr5");
            chk($sformatf("tlr5.ir_%0h", s), 32'(ir), 32'h0C);
            chk($sformatf("tlr5.drselect_%0h", s), 32'(sel), 32'b0010);
        end

        for (int k = 0; k < 1500; k++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
